nbr_cnt_gen: RTL and testbench

Neighbour-count generator for the life-game datapath. Accepts a raster-ordered stream of cell states, buffers two rows, and emits for every cell its live-neighbour count (0..8) together with the cell's own state. It is the upstream driver of the range checkers: `cnt_out`/`cnt_oen` connect directly to their count/enable inputs, which are sized for a maximum of 8.

---
 rtl/nbr_cnt_gen.sv | 126 ++++++++++++
 tb/tb_nbr_cnt_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nbr_cnt_gen.sv
// Neighbour-count generator: streams raster-ordered cells through a two-row history
// and emits each cell's live-neighbour count (0..8) with the cell's own state.
module nbr_cnt_gen #(
  parameter int GP_WIDTH  = 16,
  parameter int GP_HEIGHT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cell_in,
  input  logic       cell_ien,
  output logic       cell_rdy,
  output logic [3:0] cnt_out,
  output logic       cell_out,
  output logic       cnt_oen,
  output logic       out_last
);

  localparam int XW = $clog2(GP_WIDTH);
  localparam int YW = $clog2(GP_HEIGHT);
  localparam int HL = 2 * GP_WIDTH + 2;
  localparam logic [XW-1:0] X_LAST = XW'(GP_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GP_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state;
  logic [HL-1:0] hist;     // hist[i] = cell accepted i+1 advances ago
  logic [XW-1:0] in_x, out_x;
  logic [YW-1:0] in_y, out_y;

  logic       accept, advance, emit, new_cell;
  logic       in_last, out_final;
  logic       at_l, at_r, at_t, at_b;
  logic [7:0] nb;

  // The window centre always trails the newest cell by GP_WIDTH+1 positions; during
  // flush, dead padding is shifted in so the same taps serve the last row.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    accept    = cell_ien && cell_rdy;
    advance   = accept || (state == FLUSH);
    new_cell  = accept && cell_in;
    in_last   = (in_x == X_LAST) && (in_y == Y_LAST);
    out_final = (out_x == X_LAST) && (out_y == Y_LAST);
    emit      = (state == FLUSH) ||
                (accept && ((state == RUN) ||
                            ((state == FILL) && (in_y == YW'(1)) && (in_x == XW'(1)))));
    at_l = (out_x == '0);
    at_r = (out_x == X_LAST);
    at_t = (out_y == '0);
    at_b = (out_y == Y_LAST);
    nb[0] = hist[2*GP_WIDTH+1] && !at_l && !at_t;
    nb[1] = hist[2*GP_WIDTH]   && !at_t;
    nb[2] = hist[2*GP_WIDTH-1] && !at_r && !at_t;
    nb[3] = hist[GP_WIDTH+1]   && !at_l;
    nb[4] = hist[GP_WIDTH-1]   && !at_r;
    nb[5] = hist[1]            && !at_l && !at_b;
    nb[6] = hist[0]            && !at_b;
    nb[7] = new_cell           && !at_r && !at_b;
  end

  // NOTE: sequential state uses non-blocking assignments; later assignments in the
  // block override earlier ones, which the counter-clear cases below rely on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hist     <= '0;
      in_x     <= '0;
      in_y     <= '0;
      out_x    <= '0;
      out_y    <= '0;
      cell_rdy <= 1'b1;
      cnt_out  <= '0;
      cell_out <= 1'b0;
      cnt_oen  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (advance) hist <= {hist[HL-2:0], new_cell};

      cnt_oen  <= emit;
      out_last <= emit && out_final;
      if (emit) begin
        cnt_out  <= 4'($countones(nb));
        cell_out <= hist[GP_WIDTH];
        if (out_x == X_LAST) begin
          out_x <= '0;
          out_y <= out_y + YW'(1);
        end else begin
          out_x <= out_x + XW'(1);
        end
      end

      if (accept) begin
        if (in_x == X_LAST) begin
          in_x <= '0;
          in_y <= in_y + YW'(1);
        end else begin
          in_x <= in_x + XW'(1);
        end
      end

      case (state)
        IDLE:  if (accept) state <= FILL;
        FILL:  if (accept && (in_y == YW'(1)) && (in_x == XW'(1))) state <= RUN;
        RUN: begin
          if (accept && in_last) begin
            state    <= FLUSH;
            cell_rdy <= 1'b0;
            in_x     <= '0;
            in_y     <= '0;
          end
        end
        FLUSH: begin
          if (out_final) begin
            state    <= IDLE;
            cell_rdy <= 1'b1;
            out_x    <= '0;
            out_y    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbr_cnt_gen.sv
// Randomised self-checking bench for nbr_cnt_gen on a 4x4 grid: a frame-level
// reference computes neighbour counts directly from the grid and handshake timing.
module tb_nbr_cnt_gen;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cell_in = 1'b0;
  logic       cell_ien = 1'b0;
  logic       cell_rdy;
  logic [3:0] cnt_out;
  logic       cell_out;
  logic       cnt_oen;
  logic       out_last;

  nbr_cnt_gen #(.GP_WIDTH(W), .GP_HEIGHT(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cell_in  (cell_in),
    .cell_ien (cell_ien),
    .cell_rdy (cell_rdy),
    .cnt_out  (cnt_out),
    .cell_out (cell_out),
    .cnt_oen  (cnt_oen),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference count straight from the grid: out-of-grid cells are dead.
  function automatic int nbr_count(input logic [N-1:0] f, input int j);
    int x = j % W;
    int y = j / W;
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          c += int'(f[(y + dy) * W + x + dx]);
    return c;
  endfunction

  logic [N-1:0] frames [0:63];
  int n_frames = 0;

  // Handshake timing reference: output follows any accept of index >= W+1, then
  // W+1 flush outputs follow the last accept while ready is held low.
  int acc_idx;
  int flush_left;
  bit exp_oen;
  bit exp_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_idx    <= 0;
      flush_left <= 0;
      exp_oen    <= 1'b0;
      exp_rdy    <= 1'b1;
    end else begin
      automatic bit take = cell_ien && exp_rdy;
      exp_oen <= (flush_left > 0) || (take && acc_idx >= W + 1);
      if (flush_left > 0) begin
        flush_left <= flush_left - 1;
        if (flush_left == 1) exp_rdy <= 1'b1;
      end
      if (take) begin
        if (acc_idx == N - 1) begin
          acc_idx    <= 0;
          flush_left <= W + 1;
          exp_rdy    <= 1'b0;
        end else begin
          acc_idx <= acc_idx + 1;
        end
      end
    end
  end

  int rd_frame = 0;
  int out_idx  = 0;
  int held_cnt = 0;
  bit held_cell = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rdy", int'(cell_rdy), 1);
      check("rst_oen", int'(cnt_oen), 0);
      check("rst_cnt", int'(cnt_out), 0);
      check("rst_cell", int'(cell_out), 0);
      check("rst_last", int'(out_last), 0);
      rd_frame  <= n_frames;
      out_idx   <= 0;
      held_cnt  <= 0;
      held_cell <= 1'b0;
    end else begin
      check("rdy", int'(cell_rdy), int'(exp_rdy));
      check("oen", int'(cnt_oen), int'(exp_oen));
      if (cnt_oen && exp_oen) begin
        if (rd_frame >= n_frames) begin
          check("extra_output", 1, 0);
        end else begin
          automatic int  ec = nbr_count(frames[rd_frame], out_idx);
          automatic bit  el = frames[rd_frame][out_idx];
          check("cnt", int'(cnt_out), ec);
          check("cell", int'(cell_out), int'(el));
          check("last", int'(out_last), int'(out_idx == N - 1));
          held_cnt  <= ec;
          held_cell <= el;
          if (out_idx == N - 1) begin
            out_idx  <= 0;
            rd_frame <= rd_frame + 1;
          end else begin
            out_idx <= out_idx + 1;
          end
        end
      end else begin
        check("hold_cnt", int'(cnt_out), held_cnt);
        check("hold_cell", int'(cell_out), int'(held_cell));
        check("last_idle", int'(out_last), 0);
      end
    end
  end

  // Presents cells until n have been accepted; the final accept lands on the next edge.
  task automatic send_frame(input logic [N-1:0] f, input int n, input int duty);
    int idx = 0;
    int guard = 0;
    frames[n_frames] = f;
    n_frames++;
    while (idx < n && guard < 2000) begin
      @(negedge clk);
      cell_ien = ($urandom_range(99) < duty);
      cell_in  = f[idx];
      if (cell_ien && cell_rdy) idx++;
      guard++;
    end
    check("send_bound", idx, n);
  endtask

  task automatic drain();
    int g = 0;
    while (rd_frame != n_frames && g < 300) begin
      @(negedge clk);
      cell_ien = 1'b0;
      cell_in  = 1'($urandom);
      g++;
    end
    check("drain", rd_frame, n_frames);
    repeat (3) @(negedge clk);
  endtask

  logic [N-1:0] single;

  initial begin
    single    = '0;
    single[5] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send_frame('0, N, 100);               // all dead
    drain();
    send_frame(single, N, 100);           // single live cell at (1,1)
    drain();
    send_frame('1, N, 100);               // all alive
    drain();
    send_frame(single, N, 50);            // gaps in cell_ien
    drain();
    send_frame(single, N, 100);           // ien held high through flush
    send_frame('1, N, 100);
    drain();

    send_frame(N'($urandom), 10, 100);    // partial frame, then reset
    @(posedge clk);
    #2;
    cell_ien = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send_frame(single, N, 100);
    drain();

    for (int i = 0; i < 6; i++) begin
      send_frame(N'($urandom), N, int'($urandom_range(30, 100)));
      if (i % 2 == 1) drain();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
